// File: rtl/hht_row_accumulator_if.sv
// Pair-stream input and result-FIFO output bundle of hht_row_accumulator.
// Both channels use valid/ready: a beat transfers on a rising edge where valid & ready are both high;
// the source holds its payload stable while valid is high and ready is low.
interface hht_row_accumulator_if #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  parameter int ROW_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_mval;
  logic [DATA_W-1:0] in_vval;
  logic              in_last;
  logic              in_empty;
  logic              out_valid;
  logic              out_ready;
  logic [ROW_W-1:0]  out_row;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;

  modport master (
    output in_valid, in_mval, in_vval, in_last, in_empty, out_ready,
    input  in_ready, out_valid, out_row, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_mval, in_vval, in_last, in_empty, out_ready,
    output in_ready, out_valid, out_row, out_sum, out_ovf
  );
endinterface

// File: rtl/hht_row_accumulator.sv
// Multiply/accumulate stage of the HHT SpMV engine: sums (mval*vval) per row into a small result FIFO.
// Define HHT_ACC_SAT_EN for unsigned saturating accumulation with a sticky per-row overflow flag.
module hht_row_accumulator #(
  parameter int DATA_W     = 32,
  parameter int ACC_W      = 64,
  parameter int ROW_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                Clk,
  input  logic                Rst,
  hht_row_accumulator_if.slave bus,
  output logic [ROW_W-1:0]    rows_done,
  output logic                busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ROW_W + ACC_W + 1;

  logic                s1_valid_q, s1_valid_d;
  logic                s1_last_q, s1_last_d;
  logic [ACC_W-1:0]    s1_prod_q, s1_prod_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                partial_q, partial_d;
  logic [ROW_W-1:0]    row_ctr_q, row_ctr_d;
  logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [2*DATA_W-1:0] mul;
  logic                in_fire, push, pop, pending_last;
  logic [CNT_W-1:0]    occupancy;
  logic [ACC_W-1:0]    sum;
  logic                row_ovf;
  logic [ENT_W-1:0]    head;

  // A pop in this cycle frees a slot combinationally; a last beat in stage 1 has a slot reserved.
  assign pending_last  = s1_valid_q & s1_last_q;
  assign pop           = bus.out_valid & bus.out_ready;
  assign occupancy     = count_q - CNT_W'(pop) + CNT_W'(pending_last);
  assign bus.in_ready  = occupancy < CNT_W'(FIFO_DEPTH);
  assign in_fire       = bus.in_valid & bus.in_ready;
  assign mul           = bus.in_mval * bus.in_vval;
  assign push          = pending_last;

  always_comb begin
    s1_valid_d = in_fire;
    s1_last_d  = s1_last_q;
    s1_prod_d  = s1_prod_q;
    if (in_fire) begin
      s1_last_d = bus.in_last | bus.in_empty;
      s1_prod_d = bus.in_empty ? '0 : ACC_W'(mul);
    end
  end

`ifdef HHT_ACC_SAT_EN
  logic [ACC_W:0] sum_wide;
  logic           ovf_q, ovf_d;

  assign sum_wide = {1'b0, acc_q} + {1'b0, s1_prod_q};
  assign sum      = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
  assign row_ovf  = ovf_q | sum_wide[ACC_W];

  always_comb begin
    ovf_d = ovf_q;
    if (s1_valid_q) ovf_d = s1_last_q ? 1'b0 : row_ovf;
  end

  always_ff @(posedge Clk) begin
    if (Rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
`else
  assign sum     = acc_q + s1_prod_q;
  assign row_ovf = 1'b0;
`endif

  always_comb begin
    acc_d     = acc_q;
    partial_d = partial_q;
    row_ctr_d = row_ctr_q;
    if (s1_valid_q) begin
      if (s1_last_q) begin
        acc_d     = '0;
        partial_d = 1'b0;
        row_ctr_d = row_ctr_q + ROW_W'(1);
      end else begin
        acc_d     = sum;
        partial_d = 1'b1;
      end
    end
  end

  // FIFO occupancy never exceeds FIFO_DEPTH because in_ready reserves a slot for every accepted last beat.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_prod_q  <= '0;
      acc_q      <= '0;
      partial_q  <= 1'b0;
      row_ctr_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_prod_q  <= s1_prod_d;
      acc_q      <= acc_d;
      partial_q  <= partial_d;
      row_ctr_q  <= row_ctr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= {row_ctr_q, sum, row_ovf};
  end

  // Head fields read as zero while empty so stale storage never leaks out.
  assign head          = mem_q[rd_ptr_q];
  assign bus.out_valid = count_q != '0;
  assign bus.out_row   = bus.out_valid ? head[ENT_W-1 -: ROW_W] : '0;
  assign bus.out_sum   = bus.out_valid ? head[ACC_W:1] : '0;
  assign bus.out_ovf   = bus.out_valid & head[0];
  assign rows_done     = row_ctr_q;
  assign busy          = s1_valid_q | partial_q;
endmodule

// File: doc/hht_row_accumulator.md
# hht_row_accumulator

Downstream compute stage of the HHT sparse matrix-vector engine. Consumes the stream of (matrix value, vector value) pairs that the HHT `control` front end fetches from the CSR arrays (row pointers, column indices, values). Multiplies and accumulates each pair into a per-row dot product, tags it with a row index and buffers it in a small output FIFO for the write-back stage. It has a two-stage pipeline (multiply, accumulate) with valid/ready handshakes on both sides.

## Interface
- `DATA_W`, 32: width of matrix and vector operands (unsigned).
- `ACC_W`, 64: accumulator and result width; must be ≥ 2*`DATA_W`.
- `ROW_W`, 16: row index width.
- `FIFO_DEPTH`, 4: result FIFO entries (power of two, ≥ 2).

- `Clk`  in  1  clock, rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  pair beat valid.
- `in_ready`  out  1  beat accepted when `in_valid & in_ready` at rising edge.
- `in_mval`  in  `DATA_W`  matrix nonzero value.
- `in_vval`  in  `DATA_W`  gathered vector value.
- `in_last`  in  1  beat is final nonzero of current row.
- `in_empty`  in  1  empty-row token: row has no nonzeros; operands ignored, implies `in_last`.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer pops head when `out_valid & out_ready`.
- `out_row`  out  `ROW_W`  row index of head result.
- `out_sum`  out  `ACC_W`  dot product of head row.
- `out_ovf`  out  1  head row saturated (see Configuration).
- `rows_done`  out  `ROW_W`  count of rows completed into FIFO.
- `busy`  out  1  any beat in pipeline or partial row in accumulator.

## Operation
- Stage 1 (MUL): on accept, register `prod = in_mval*in_vval` (zero if `in_empty`), zero-extended to `ACC_W`, plus `last` and valid flags.
- Stage 2 (ACC): when stage-1 valid, `sum = acc + prod`. If `last`: push {row_ctr, sum, ovf} to FIFO, clear `acc` and ovf flag, increment `row_ctr`. Otherwise `acc <= sum`.
- `row_ctr` starts at 0 and wraps modulo 2^`ROW_W`. `rows_done` equals `row_ctr`.
- Flow control: `in_ready = (fifo_count + pending_last) < FIFO_DEPTH`, where `pending_last` is 1 if stage 1 holds a `last` beat. A FIFO push can therefore never be blocked, and stage 2 never stalls.
- FIFO: simultaneous push and pop in one cycle leaves the count unchanged. A pop when empty is ignored. Head outputs are stable while `out_valid & !out_ready`.
- Non-last beats are always accepted when `in_ready` is high. Back-pressure only arises from result buffering.
- `busy = stage1_valid | (acc_has_partial)`, where `acc_has_partial` is set by a non-last accumulate and cleared by last.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_row`=0, `out_sum`=0, `out_ovf`=0, `rows_done`=0, `busy`=0. The pipeline, accumulator and FIFO are cleared.
- Reset mid-row discards the partial accumulation and all buffered results. The first row after reset is row 0.
- Latency: a last beat accepted at edge E0 is written to the FIFO at E1. `out_valid` is high in the cycle after E1 (2 edges acceptance-to-visible).
- Throughput: one beat per cycle sustained while the FIFO has space.
- Full FIFO: `in_ready`=0 until a pop; in the pop cycle `in_ready` rises combinationally only if the count condition holds.
- Back-to-back last beats (consecutive single-element or empty rows) each produce one FIFO entry per cycle.

## Configuration
- `HHT_ACC_SAT_EN` defined: accumulation is unsigned saturating. If `acc + prod` ≥ 2^`ACC_W`, `acc` clamps to all-ones and the row's ovf flag is set sticky until that row is pushed. `out_ovf` reports it.
- Undefined: accumulation wraps modulo 2^`ACC_W`, and `out_ovf` is tied to 0.

## Test plan
- Row 0 of the 16x16 set: beats (30,6),(25,0),(89,95),(98,73,last), `out_ready`=1 -> `out_row`=0, `out_sum`=15789, `out_valid` 2 edges after the last accept, `rows_done`=1.
- Empty-row token then single beat (7,3,last) -> two entries: row 0 sum 0, row 1 sum 21.
- `out_ready`=0, stream 6 single-beat rows -> 4 entries buffered, `in_ready`=0 with FIFO full. Popping one admits the next row. Order and indices 0..5 are preserved.
- Assert `Rst` after 2 of 4 beats of a row, then a fresh row (5,5,last) -> sum 25, `out_row`=0, no stale data.
- `DATA_W`=8, `ACC_W`=16, beats (255,255),(255,255,last): with `HHT_ACC_SAT_EN` -> sum 65535, `out_ovf`=1. Without -> sum 64514, `out_ovf`=0.
- `ROW_W`=2, 5 rows -> fifth `out_row`=0 (wrap).
